// File: rtl/nibble_frame_packer.sv
// nibble_frame_packer: packs a valid/ready nibble stream into LANES-wide frames,
// with early termination (zero fill) and a one-frame skid buffer ahead of the output register.
module nibble_frame_packer #(
    parameter int LANES = 5,
    parameter int NIB_W = 4,
    parameter int CNT_W = $clog2(LANES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIB_W-1:0]            in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES-1:0][NIB_W-1:0] out_frame,
    output logic [NIB_W-1:0]            out_lane0,
    output logic [CNT_W-1:0]            out_count,
    output logic [7:0]                  frame_cnt
);
    localparam logic [0:0] FILL = 1'b0, STALL = 1'b1;
    logic [LANES-1:0][NIB_W-1:0] asm_q, asm_d, merged, out_frame_q, out_frame_d;
    logic [CNT_W-1:0] idx_q, idx_d, asm_cnt_q, asm_cnt_d, out_count_q, out_count_d;
    logic [0:0] state_q, state_d;
    logic out_valid_q, out_valid_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic slot_free, accept, done;
    assign slot_free = !out_valid_q || out_ready;
    assign accept    = in_valid && state_q == FILL;
    assign done      = accept && (idx_q == CNT_W'(LANES - 1) || in_last);
    // asm is cleared after every frame, so lanes above idx are already zero
    always_comb begin
        merged         = asm_q;
        merged[idx_q]  = in_data;
    end
    always_comb begin
        asm_d       = asm_q;
        idx_d       = idx_q;
        asm_cnt_d   = asm_cnt_q;
        state_d     = state_q;
        out_frame_d = out_frame_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q && !out_ready;
        frame_cnt_d = frame_cnt_q + 8'(out_valid_q && out_ready);
        if (state_q == STALL && slot_free) begin
            out_frame_d = asm_q;
            out_count_d = asm_cnt_q;
            out_valid_d = 1'b1;
            asm_d       = '0;
            idx_d       = '0;
            state_d     = FILL;
        end else if (done && slot_free) begin
            out_frame_d = merged;
            out_count_d = idx_q + CNT_W'(1);
            out_valid_d = 1'b1;
            asm_d       = '0;
            idx_d       = '0;
        end else if (done) begin
            asm_d     = merged;
            asm_cnt_d = idx_q + CNT_W'(1);
            state_d   = STALL;
        end else if (accept) begin
            asm_d = merged;
            idx_d = idx_q + CNT_W'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= '0;
            idx_q       <= '0;
            asm_cnt_q   <= '0;
            state_q     <= FILL;
            out_frame_q <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            asm_cnt_q   <= asm_cnt_d;
            state_q     <= state_d;
            out_frame_q <= out_frame_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
    assign in_ready  = state_q == FILL;
    assign out_valid = out_valid_q;
    assign out_frame = out_frame_q;
    assign out_lane0 = out_frame_q[0];
    assign out_count = out_count_q;
    assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_nibble_frame_packer.sv
// tb_nibble_frame_packer: table vectors, hand sequences and random traffic checked
// against a queue-of-frames reference model.
module tb_nibble_frame_packer;
    localparam int LANES = 5;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, in_last = 1'b0, out_valid, out_ready = 1'b0;
    logic [3:0] in_data = '0, out_lane0;
    logic [LANES-1:0][3:0] out_frame;
    logic [2:0] out_count;
    logic [7:0] frame_cnt;

    nibble_frame_packer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_frame(out_frame), .out_lane0(out_lane0), .out_count(out_count), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [LANES-1:0][3:0] f; logic [2:0] c; } frm_t;
    typedef struct {
        logic v; logic [3:0] d; logic l; logic r;
        logic ev; logic [19:0] ef; logic [2:0] ec; logic [7:0] efc;
    } vec_t;

    frm_t q[$];
    logic [3:0] cur[$];
    int dlv = 0, checks = 0, passes = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    endtask

    // completed-but-undelivered frames: front sits in the output register, a second one in the skid buffer
    task automatic cyc(input logic v, input logic [3:0] d, input logic l, input logic r);
        logic acc, hs;
        frm_t nf;
        in_valid = v; in_data = d; in_last = l; out_ready = r;
        #1;
        acc = in_valid && in_ready;
        hs  = out_valid && out_ready;
        if (hs) begin
            if (q.size() > 0) void'(q.pop_front());
            dlv++;
        end
        if (acc) begin
            cur.push_back(d);
            if (cur.size() == LANES || l) begin
                nf.f = '0;
                foreach (cur[i]) nf.f[i] = cur[i];
                nf.c = 3'(cur.size());
                q.push_back(nf);
                cur.delete();
            end
        end
        @(negedge clk);
        chk("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("m_frame_cnt", 32'(frame_cnt), 32'(dlv % 256));
        if (q.size() > 0) begin
            chk("m_out_frame", 32'(out_frame), 32'(q[0].f));
            chk("m_out_count", 32'(out_count), 32'(q[0].c));
            chk("m_out_lane0", 32'(out_lane0), 32'(q[0].f[0]));
        end
    endtask

    vec_t tbl[14];
    int lows, base;

    initial begin
        tbl[0]  = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd0};
        tbl[1]  = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd0};
        tbl[2]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd0};
        tbl[3]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd0};
        tbl[4]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 20'h54321, 3'd5, 8'd0};
        tbl[5]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd1};
        tbl[6]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd1};
        tbl[7]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd1};
        tbl[8]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd1};
        tbl[9]  = '{1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 20'hFFFFF, 3'd5, 8'd1};
        tbl[10] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd2};
        tbl[11] = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b1, 20'h000BA, 3'd2, 8'd2};
        tbl[12] = '{1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 20'h00007, 3'd1, 8'd3};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 20'h0,     3'd0, 8'd4};

        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_frame", 32'(out_frame), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_fcnt", i), 32'(frame_cnt), 32'(tbl[i].efc));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_frame", i), 32'(out_frame), 32'(tbl[i].ef));
                chk($sformatf("tbl%0d_count", i), 32'(out_count), 32'(tbl[i].ec));
            end
        end

        for (int i = 0; i < 10; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        chk("bp_hold_frame", 32'(out_frame), 32'h43210);
        for (int i = 0; i < 2; i++) cyc(1'b1, 4'hE, 1'b0, 1'b0);
        chk("bp_stable_frame", 32'(out_frame), 32'h43210);
        chk("bp_stable_ready", 32'(in_ready), 0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("bp_next_frame", 32'(out_frame), 32'h98765);
        chk("bp_next_count", 32'(out_count), 5);
        chk("bp_in_ready_back", 32'(in_ready), 1);
        chk("bp_frame_cnt", 32'(frame_cnt), 5);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);

        lows = 0;
        base = dlv;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 4'($urandom), 1'b0, 1'b1);
            if (!in_ready) lows++;
        end
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("cont_ready_lows", 32'(lows), 0);
        chk("cont_frames", 32'(frame_cnt), 32'((base + 8) % 256));

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("drain_empty", 32'(out_valid), 0);

        for (int k = 0; k < 800 && (k < 256 || dlv % 256 != 254); k++) cyc(1'b1, 4'($urandom), 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("wrap_255", 32'(frame_cnt), 255);
        cyc(1'b1, 4'h3, 1'b1, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("wrap_0", 32'(frame_cnt), 0);

        for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_frame", 32'(out_frame), 0);
        chk("mid_rst_count", 32'(out_count), 0);
        chk("mid_rst_fcnt", 32'(frame_cnt), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        q.delete();
        cur.delete();
        dlv = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 9; i <= 13; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
        chk("post_rst_frame", 32'(out_frame), 32'hDCBA9);
        chk("post_rst_count", 32'(out_count), 5);
        chk("post_rst_fcnt", 32'(frame_cnt), 0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        chk("post_rst_fcnt1", 32'(frame_cnt), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
